// File: rtl/pll_rstseq_pkg.sv
// Shared types and constants for the PLL reset sequencer: FSM state encoding,
// lock-loss counter sizing and a helper that sizes the sequencing counter.
package pll_rstseq_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    FILTER,
    HOLD,
    RELEASE,
    RUN
  } state_e;

  localparam int              LOSS_CNT_W   = 8;
  localparam logic [7:0]      LOSS_CNT_MAX = 8'd255;

  // One counter is reused by FILTER, HOLD and RELEASE, so it must hold the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL lock / staged domain reset bundle. master = the sequencer, slave = the
// PLL-lock source plus the downstream reset consumers.
interface pll_reset_sequencer_if #(
  parameter int N_DOMAINS = 3
);
  import pll_rstseq_pkg::*;

  logic                  lock_in;
  logic [N_DOMAINS-1:0]  rst_out;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_count;

  // No valid/ready handshake: lock_in is a level from the PLL, rst_out/ready are levels held until changed.
  modport master (input lock_in, output rst_out, output ready, output lock_loss_count);
  modport slave  (output lock_in, input rst_out, input ready, input lock_loss_count);
endinterface

// File: rtl/pll_reset_sequencer_lock_synchronizer.sv
// Plain flop chain bringing the asynchronous PLL LOCK into the clk_in domain.
// Deliberately reset-free; the sequencer FSM owns all reset behaviour.
module lock_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
  end

  always_ff @(posedge clk_in) begin
    sync_q <= sync_d;
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Filters PLL lock and releases staged domain resets in index order; any lock
// loss re-asserts them all. Lock-loss counter built only with PLL_RSTSEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import pll_rstseq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 256,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int N_DOMAINS   = 3
) (
  input  logic                   clk_in,
  input  logic                   rst,
  pll_reset_sequencer_if.master  bus,
  output state_e                 dbg_state
);

  localparam int CNT_W = cnt_width(LOCK_FILTER, HOLD_CYCLES, (N_DOMAINS - 1) * STAGE_GAP);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((N_DOMAINS - 1) * STAGE_GAP);

  logic                 lock_sync;
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                 ready_q, ready_d;
  logic                 loss_evt;

  lock_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk_in   (clk_in),
    .async_in (bus.lock_in),
    .sync_out (lock_sync)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    loss_evt  = 1'b0;
    if (!lock_sync && (state_q == FILTER || state_q == HOLD ||
                       state_q == RELEASE || state_q == RUN)) begin
      // Any loss discards all progress: filter and hold restart from zero.
      loss_evt  = 1'b1;
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_sync) begin
            state_d = FILTER;
            cnt_d   = '0;
          end
        end
        FILTER: begin
          if (cnt_q == FILT_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d        = '0;
            rst_out_d[0] = 1'b0;
            if (N_DOMAINS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          cnt_d = cnt_q + 1'b1;
          for (int k = 1; k < N_DOMAINS; k++) begin
            if (cnt_d == CNT_W'(k * STAGE_GAP)) rst_out_d[k] = 1'b0;
          end
          if (cnt_d == REL_LAST) begin
            state_d = RUN;
            ready_d = 1'b1;
            cnt_d   = '0;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d   = RESET;
          cnt_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= RESET;
      cnt_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (loss_evt && loss_cnt_q != LOSS_CNT_MAX) loss_cnt_d = loss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst) loss_cnt_q <= '0;
    else     loss_cnt_q <= loss_cnt_d;
  end

  assign bus.lock_loss_count = loss_cnt_q;
`else
  logic unused_loss_evt;
  assign unused_loss_evt     = loss_evt;
  assign bus.lock_loss_count = '0;
`endif

  assign bus.rst_out = rst_out_q;
  assign bus.ready   = ready_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumer end of the PLL lock interface: synchronizes the PLL's asynchronous LOCK output into the 48 MHz PLL clock domain and filters it. It then releases a set of staged, active-high domain resets in a fixed order once lock has been stable long enough. On loss of lock it re-asserts all domain resets, returns to waiting, and counts the loss events. It sits directly behind the 48 MHz PLL and drives the resets of every downstream block.

## Interface
- SYNC_STAGES, 2: flops in the lock synchronizer; legal values are 2 or more.
- LOCK_FILTER, 256: consecutive synchronized-high cycles required before lock is accepted; legal values are 1 or more.
- HOLD_CYCLES, 16: cycles all resets stay asserted after lock is accepted; legal values are 1 or more.
- STAGE_GAP, 4: cycles between successive domain reset releases; legal values are 1 or more.
- N_DOMAINS, 3: number of staged reset outputs; legal values are 1 or more.
- clk_in  in  1  the 48 MHz PLL output clock; the single clock of this block.
- rst  in  1  reset, synchronous to clk_in and active-high.
- lock_in  in  1  PLL LOCK; asynchronous to clk_in.
- rst_out  out  N_DOMAINS  domain resets, active-high; bit 0 is released first.
- ready  out  1  high when every domain reset is released.
- lock_loss_count  out  8  saturating count of lock-loss events.

## Operation
- lock_sync is lock_in passed through SYNC_STAGES flops. All decisions below use lock_sync.
- State machine:
  - RESET: entered from rst. Moves to WAIT_LOCK on the next cycle.
  - WAIT_LOCK: moves to FILTER when lock_sync=1.
  - FILTER: counts lock_sync=1 cycles. After LOCK_FILTER cycles, moves to HOLD.
  - HOLD: counts HOLD_CYCLES, then moves to RELEASE.
  - RELEASE: clears rst_out[k] at k*STAGE_GAP cycles after entry. Moves to RUN when the last bit clears.
  - RUN: steady state with all domains released.
- Lock loss: lock_sync=0 while in FILTER, HOLD, RELEASE or RUN.
  - At the next edge: rst_out becomes all ones, ready becomes 0, and the state becomes WAIT_LOCK.
  - lock_loss_count increments by 1 per event and saturates at 255.
- lock_sync=0 in WAIT_LOCK is not an event.
- Each lock loss restarts the filter and hold counters from zero. No partial credit carries over.
- ready = (state == RUN). It is registered and changes on the same edge as the final rst_out bit.
- rst_out bits only ever go from 1 to 0 in index order. Any lock loss or rst drives all bits to 1 together.

## Timing
- Reset values (while rst=1 and on the first cycle after it deasserts):
  - rst_out is all ones.
  - ready=0.
  - lock_loss_count=0.
  - state=RESET.
  - All counters are 0.
- rst takes priority over lock_in in every state, including mid-RELEASE.
- Release timing: lock_in rises and is stable before edge E0.
  - rst_out[0] falls at edge E0 + SYNC_STAGES + LOCK_FILTER + HOLD_CYCLES.
  - rst_out[k] falls k*STAGE_GAP edges after rst_out[0].
  - ready rises with rst_out[N_DOMAINS-1].
- Lock-loss response: lock_in falls before edge E1.
  - rst_out becomes all ones at edge E1 + SYNC_STAGES.
  - lock_loss_count updates on that same edge.
- A lock_in low pulse shorter than one clock period may be missed. That is acceptable.
- Counter widths are the ceiling of log2(max(LOCK_FILTER, HOLD_CYCLES, (N_DOMAINS-1)*STAGE_GAP)+1).

## Configuration
- PLL_RSTSEQ_LOSS_CNT_EN
  - Defined: the lock_loss_count register and its saturation logic are built as described above.
  - Undefined: lock_loss_count is tied to 8'd0. No counter flops are synthesized. Sequencing behaviour is unchanged.

## Structure
- Shared package pll_rstseq_pkg contains:
  - The state enum: RESET, WAIT_LOCK, FILTER, HOLD, RELEASE, RUN.
  - LOSS_CNT_W = 8.
  - LOSS_CNT_MAX = 255.
- One sub-module, lock_synchronizer: a SYNC_STAGES-deep flop chain. It has no reset, so that metastability handling stays clean. The top-level FSM resets.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, LOCK_FILTER=8, HOLD_CYCLES=4, STAGE_GAP=2, N_DOMAINS=3.
- Power-up: rst high for 5 cycles, lock_in=0 → rst_out=3'b111, ready=0 and count=0 throughout; state reaches WAIT_LOCK.
- Clean lock: lock_in rises before edge 0 → rst_out[0] falls at edge 14, rst_out[1] at 16, rst_out[2] at 18; ready=1 from edge 18.
- Filter glitch: lock_in low for 3 cycles during FILTER → rst_out stays 3'b111, count=1, and the full 8-cycle filter restarts.
- Loss in RUN: lock_in falls before edge 100 → rst_out=3'b111 and ready=0 at edge 102; count increments by 1; re-lock releases again with the clean-lock spacing.
- Saturation: 300 loss events → lock_loss_count=255 (macro defined) or 0 (macro undefined).
- Reset mid-RELEASE: rst pulsed at edge 15 → rst_out=3'b111 at edge 16, count=0; re-sequencing follows the clean-lock timing measured from the rst release.
